click_classifier: RTL and testbench
===================================

# click_classifier

Downstream consumer of the button debouncer's single-cycle press pulse. Groups press pulses that arrive within a programmable inactivity window into one "burst" (single, double, triple click). Pushes each classified burst as an event into a small FIFO with a valid/ready output port for the control logic or display stage.

## Interface
- WINDOW_CYCLES, 15_000_000, inactivity window in clk_i cycles (300 ms at 50 MHz); legal range 2 .. 2^32-1
- MAX_CLICKS, 3, burst length that closes a burst immediately; legal range 2 .. 7
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- CW (local), $clog2(MAX_CLICKS+1), event width
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- btn_pulse_i  input  1  press pulse from debouncer, one cycle per press, synchronous to clk_i
- evt_valid_o  output  1  FIFO head holds an event
- evt_count_o  output  CW  click count of head event (1 .. MAX_CLICKS)
- evt_ready_i  input  1  consumer accepts head event
- drop_o  output  1  one-cycle pulse: event lost because FIFO full
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  number of stored events

## Operation
- FSM states: IDLE, GATHER. Registers: clicks (CW bits), timer (32 bits), FIFO storage, read/write pointers with extra wrap bit.
- IDLE: btn_pulse_i=1 -> GATHER, clicks<=1, timer<=0. Otherwise hold.
- GATHER, btn_pulse_i=1: clicks<=clicks+1, timer<=0. If clicks+1 == MAX_CLICKS, push event MAX_CLICKS, go IDLE.
- GATHER, no pulse, timer == WINDOW_CYCLES-1: push event clicks, go IDLE. Otherwise timer<=timer+1.
- A pulse in the timeout cycle takes priority: it counts as a click and restarts the timer; no push from the timeout.
- Push when FIFO full and no pop in the same cycle: event discarded, drop_o=1 for that cycle, FIFO unchanged, FSM still returns to IDLE.
- Pop: evt_valid_o & evt_ready_i at a clock edge removes the head. evt_ready_i while empty has no effect.
- Simultaneous push and pop: both take effect, level unchanged. This also applies when full: the pop frees the slot and the push is accepted without a drop.
- FIFO is first-word-fall-through. evt_valid_o = (level != 0). evt_count_o is the head entry and is stable while evt_valid_o=1 and evt_ready_i=0.
- Pointers wrap modulo FIFO_DEPTH. Full = pointers equal except the wrap bit.
- Reset (any time, including mid-burst): state IDLE, clicks=0, timer=0, FIFO empty. Outputs are evt_valid_o=0, evt_count_o=0, drop_o=0, fifo_level_o=0. The partial burst and queued events are discarded.

## Timing
- All state changes on the rising edge of clk_i; outputs are registered or derived from FIFO registers only, with no combinational path from inputs.
- Timeout latency: the edge that samples the last pulse is E0. The push occurs at edge E0+WINDOW_CYCLES. evt_valid_o is high in the cycle after that edge.
- MAX_CLICKS latency: the push occurs at the edge sampling the MAX_CLICKS-th pulse. evt_valid_o is high the cycle after.
- Pulses spaced ≤ WINDOW_CYCLES edges apart (edge to edge) belong to the same burst. Spacing WINDOW_CYCLES+1 edges or more starts a new burst.
- Pop latency: level decrements and the next head appears the cycle after the accepting edge.
- drop_o is high exactly the one cycle after the failed push edge.

## Test plan
Simulation parameters: WINDOW_CYCLES=8, MAX_CLICKS=3, FIFO_DEPTH=4.
- Single pulse, evt_ready_i=0 -> evt_valid_o rises 8 edges later, evt_count_o=1, fifo_level_o=1.
- Two pulses 5 cycles apart -> one event, count 2, issued 8 edges after the 2nd pulse. Two pulses 9 cycles apart -> two events, each count 1.
- Three pulses 2 cycles apart -> event count 3 valid the cycle after the 3rd pulse, no timeout event afterwards. A 4th pulse 2 cycles later starts a new burst -> count 1.
- Five single-click bursts with evt_ready_i=0 -> level 4, the 5th push gives drop_o pulse. Then hold ready=1 -> counts 1,1,1,1 drain in 4 cycles, level 0, valid low.
- FIFO full while a push coincides with a pop -> no drop_o, level stays 4, order preserved.
- Pulse in the exact timeout cycle -> burst continues (count 2). Assert rst_i mid-GATHER with 2 queued events -> all outputs 0 immediately. No event after reset release.

Source files
------------

// File: rtl/click_classifier.sv
// rtl/click_classifier.sv - groups debounced press pulses into click bursts and queues them as events
module click_classifier #(
  parameter int unsigned WINDOW_CYCLES = 15_000_000,
  parameter int unsigned MAX_CLICKS    = 3,
  parameter int unsigned FIFO_DEPTH    = 4,
  localparam int unsigned CW           = $clog2(MAX_CLICKS + 1),
  localparam int unsigned AW           = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          btn_pulse_i,
  output logic          evt_valid_o,
  output logic [CW-1:0] evt_count_o,
  input  logic          evt_ready_i,
  output logic          drop_o,
  output logic [AW:0]   fifo_level_o
);

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_CLICKS);
  localparam logic [31:0]   LAST_T = 32'(WINDOW_CYCLES - 1);

  typedef enum logic {IDLE, GATHER} state_t;

  state_t        state;
  logic [CW-1:0] clicks;
  logic [CW-1:0] clicks_inc;
  logic [31:0]   timer;

  logic          push;
  logic [CW-1:0] push_count;

  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign clicks_inc = clicks + 1'b1;

  // Decide whether the burst closes this cycle; a pulse always beats the timeout.
  always_comb begin
    push       = 1'b0;
    push_count = clicks;
    if (state == GATHER) begin
      if (btn_pulse_i) begin
        if (clicks_inc == MAX_C) begin
          push       = 1'b1;
          push_count = MAX_C;
        end
      end else if (timer == LAST_T) begin
        push = 1'b1;
      end
    end
  end

  // Burst tracker: counts clicks and restarts the inactivity window on each pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      clicks <= '0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_pulse_i) begin
            state  <= GATHER;
            clicks <= CW'(1);
            timer  <= '0;
          end
        end
        GATHER: begin
          if (btn_pulse_i) begin
            clicks <= clicks_inc;
            timer  <= '0;
            if (clicks_inc == MAX_C) begin
              state <= IDLE;
            end
          end else if (timer == LAST_T) begin
            state <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && evt_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign wr_en = push && (!full || pop);

  // Event storage; contents only matter between the pointers, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= push_count;
    end
  end

  // FIFO pointers and the registered drop indication.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr   <= '0;
      rptr   <= '0;
      drop_o <= 1'b0;
    end else begin
      drop_o <= push && full && !pop;
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  assign evt_valid_o  = !empty;
  assign evt_count_o  = empty ? '0 : mem[rptr[AW-1:0]];
  assign fifo_level_o = wptr - rptr;

endmodule

// File: tb/tb_click_classifier.sv
// tb/tb_click_classifier.sv - self-checking bench for click_classifier with a burst/queue reference model
module tb_click_classifier;

  localparam int W     = 8;
  localparam int MAXC  = 3;
  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       btn   = 1'b0;
  logic       ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_count;
  logic       drop;
  logic [2:0] level;

  int n_cmp  = 0;
  int n_fail = 0;

  int q[$];
  bit m_active = 1'b0;
  int m_n      = 0;
  int m_since  = 0;
  bit m_drop   = 1'b0;

  always #5 clk = ~clk;

  click_classifier #(
    .WINDOW_CYCLES(W),
    .MAX_CLICKS   (MAXC),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .btn_pulse_i (btn),
    .evt_valid_o (evt_valid),
    .evt_count_o (evt_count),
    .evt_ready_i (ready),
    .drop_o      (drop),
    .fifo_level_o(level)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: pulses no more than W edges apart share a burst; a burst ends at MAXC clicks
  // or after W pulse-free edges. Pops are resolved before pushes on the same edge.
  task automatic model_step();
    bit pop;
    bit emit;
    int ev;
    pop  = (q.size() != 0) && ready;
    emit = 1'b0;
    ev   = 0;
    if (btn) begin
      if (m_active) m_n = m_n + 1;
      else begin
        m_n      = 1;
        m_active = 1'b1;
      end
      m_since = 0;
      if (m_n == MAXC) begin
        emit     = 1'b1;
        ev       = m_n;
        m_active = 1'b0;
      end
    end else if (m_active) begin
      m_since = m_since + 1;
      if (m_since == W) begin
        emit     = 1'b1;
        ev       = m_n;
        m_active = 1'b0;
      end
    end
    m_drop = 1'b0;
    if (pop) void'(q.pop_front());
    if (emit) begin
      if (q.size() < DEPTH) q.push_back(ev);
      else m_drop = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_active = 1'b0;
      m_n      = 0;
      m_since  = 0;
      m_drop   = 1'b0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    check("valid", int'(evt_valid), int'(q.size() != 0));
    check("count", int'(evt_count), (q.size() != 0) ? q[0] : 0);
    check("level", int'(level), q.size());
    check("drop", int'(drop), int'(m_drop));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic pop1();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_count", int'(evt_count), 0);
    check("rst_drop", int'(drop), 0);
    rst = 1'b0;
    tick(2);

    // single click, valid exactly 8 edges after the pulse
    pulse();
    tick(7);
    check("single_early", int'(evt_valid), 0);
    tick(1);
    check("single_valid", int'(evt_valid), 1);
    check("single_count", int'(evt_count), 1);
    check("single_level", int'(level), 1);
    pop1();
    check("single_popped", int'(level), 0);

    // two pulses 5 apart -> one double click
    pulse();
    tick(4);
    pulse();
    tick(7);
    check("dbl_early", int'(evt_valid), 0);
    tick(1);
    check("dbl_count", int'(evt_count), 2);
    check("dbl_level", int'(level), 1);
    pop1();

    // two pulses 9 apart -> two single clicks
    pulse();
    tick(8);
    pulse();
    tick(8);
    check("split_level", int'(level), 2);
    check("split_head", int'(evt_count), 1);
    pop1();
    check("split_head2", int'(evt_count), 1);
    pop1();
    check("split_empty", int'(level), 0);

    // triple click closes immediately, then a 4th pulse starts a new burst
    pulse();
    tick(1);
    pulse();
    tick(1);
    pulse();
    check("tri_valid", int'(evt_valid), 1);
    check("tri_count", int'(evt_count), 3);
    tick(1);
    pulse();
    tick(7);
    check("tri_no_timeout", int'(level), 1);
    tick(1);
    check("tri_next_level", int'(level), 2);
    pop1();
    check("tri_next_count", int'(evt_count), 1);
    pop1();

    // overflow: fifth event is dropped
    repeat (4) begin
      pulse();
      tick(9);
    end
    check("full_level", int'(level), 4);
    pulse();
    tick(7);
    check("drop_before", int'(drop), 0);
    tick(1);
    check("drop_pulse", int'(drop), 1);
    check("drop_level", int'(level), 4);
    tick(1);
    check("drop_after", int'(drop), 0);
    ready = 1'b1;
    tick(6);
    ready = 1'b0;
    check("drain_level", int'(level), 0);
    check("drain_valid", int'(evt_valid), 0);

    // full FIFO with push and pop on the same edge
    pulse(); tick(1); pulse(); tick(9);
    pulse(); tick(9);
    pulse(); tick(1); pulse(); tick(9);
    pulse(); tick(9);
    check("pp_full", int'(level), 4);
    check("pp_head", int'(evt_count), 2);
    pulse();
    tick(7);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("pp_nodrop", int'(drop), 0);
    check("pp_level", int'(level), 4);
    check("pp_head_a", int'(evt_count), 1);
    ready = 1'b1;
    tick(1);
    check("pp_head_b", int'(evt_count), 2);
    tick(1);
    check("pp_head_c", int'(evt_count), 1);
    tick(1);
    check("pp_head_d", int'(evt_count), 1);
    tick(1);
    ready = 1'b0;
    check("pp_empty", int'(level), 0);

    // pulse in the timeout cycle extends the burst
    pulse();
    tick(7);
    pulse();
    tick(7);
    check("edge_early", int'(evt_valid), 0);
    tick(1);
    check("edge_count", int'(evt_count), 2);
    pop1();

    // reset mid-burst with queued events
    pulse(); tick(9);
    pulse(); tick(9);
    check("pre_rst_level", int'(level), 2);
    pulse();
    tick(3);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", int'(evt_valid), 0);
    check("arst_count", int'(evt_count), 0);
    check("arst_level", int'(level), 0);
    check("arst_drop", int'(drop), 0);
    tick(2);
    rst = 1'b0;
    tick(20);
    check("post_rst_level", int'(level), 0);
    check("post_rst_valid", int'(evt_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
